// File: rtl/psram_pkg.sv
// Shared types and constants for the tangnano PSRAM QSPI controller.
// States, opcodes, lane directions and shift-engine modes.
package psram_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_RST_EN,
    ST_GAP,
    ST_RST,
    ST_CE_HIGH,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_DATA
  } psram_state_e;

  typedef enum logic [1:0] {
    SH_SPI,
    SH_QOUT,
    SH_QIN
  } shift_mode_e;

  localparam logic [7:0] PSRAM_RESET_ENABLE = 8'h66;
  localparam logic [7:0] PSRAM_RESET        = 8'h99;
  localparam logic [7:0] PSRAM_QUAD_READ    = 8'hEB;
  localparam logic [7:0] PSRAM_QUAD_WRITE   = 8'h38;

  localparam logic [3:0] SIO_DIR_SPI      = 4'b0001;
  localparam logic [3:0] SIO_DIR_QUAD_OUT = 4'b1111;
  localparam logic [3:0] SIO_DIR_IN       = 4'b0000;

  function automatic logic [31:0] msb_word(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/psram_shift_engine.sv
// SPI bit engine: sclk phases, lane drive/enable and nibble capture.
// A load on the edge that ends the last high phase chains phases seamlessly.
module psram_shift_engine
  import psram_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  shift_mode_e mode,
  input  logic [3:0]  clocks,
  input  logic [31:0] word,
  input  logic [3:0]  sio_in,
  output logic        sclk,
  output logic        ce_n,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  output logic        done,
  output logic [7:0]  rx_next
);

  logic        busy_q;
  logic        sclk_q;
  logic        ce_n_q;
  logic [3:0]  out_q;
  logic [3:0]  oe_q;
  logic [3:0]  left_q;
  logic [31:0] sh_q;
  logic [7:0]  rx_q;
  shift_mode_e mode_q;

  assign sclk    = sclk_q;
  assign ce_n    = ce_n_q;
  assign sio_out = out_q;
  assign sio_oe  = oe_q;
  assign done    = busy_q & sclk_q & (left_q == 4'd0);
  assign rx_next = {rx_q[3:0], sio_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      ce_n_q <= 1'b1;
      out_q  <= 4'h0;
      oe_q   <= SIO_DIR_IN;
      left_q <= 4'd0;
      sh_q   <= 32'h0;
      rx_q   <= 8'h00;
      mode_q <= SH_SPI;
    end else begin
      if (busy_q && sclk_q && mode_q == SH_QIN)
        rx_q <= rx_next;
      if (load) begin
        busy_q <= 1'b1;
        ce_n_q <= 1'b0;
        sclk_q <= 1'b0;
        mode_q <= mode;
        left_q <= clocks - 4'd1;
        unique case (mode)
          SH_SPI: begin
            out_q <= {3'b000, word[31]};
            sh_q  <= {word[30:0], 1'b0};
            oe_q  <= SIO_DIR_SPI;
          end
          SH_QOUT: begin
            out_q <= word[31:28];
            sh_q  <= {word[27:0], 4'h0};
            oe_q  <= SIO_DIR_QUAD_OUT;
          end
          default: begin
            out_q <= 4'h0;
            sh_q  <= word;
            oe_q  <= SIO_DIR_IN;
          end
        endcase
      end else if (busy_q) begin
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else if (left_q == 4'd0) begin
          busy_q <= 1'b0;
          ce_n_q <= 1'b1;
          sclk_q <= 1'b0;
          out_q  <= 4'h0;
          oe_q   <= SIO_DIR_IN;
        end else begin
          left_q <= left_q - 4'd1;
          sclk_q <= 1'b0;
          unique case (mode_q)
            SH_SPI: begin
              out_q <= {3'b000, sh_q[31]};
              sh_q  <= {sh_q[30:0], 1'b0};
            end
            SH_QOUT: begin
              out_q <= sh_q[31:28];
              sh_q  <= {sh_q[27:0], 4'h0};
            end
            default: out_q <= 4'h0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/psram_qspi_controller.sv
// PSRAM QSPI controller: power-up reset sequence, then single-byte
// quad read (0xEB) / quad write (0x38) transactions.
module psram_qspi_controller
  import psram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 23,
  parameter int STARTUP_CYCLES = 4050,
  parameter int CE_HIGH_CYCLES = 4,
  parameter int WAIT_CLOCKS    = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  init_done,
  output logic                  psram_sclk,
  output logic                  psram_ce_n,
  output logic [3:0]            psram_sio_out,
  output logic [3:0]            psram_sio_oe,
  input  logic [3:0]            psram_sio_in
);

  localparam int CNT_MAX = (STARTUP_CYCLES > CE_HIGH_CYCLES) ?
                           STARTUP_CYCLES : CE_HIGH_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  psram_state_e          state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic [23:0]           addr24;

  logic        ld;
  shift_mode_e ld_mode;
  logic [3:0]  ld_clocks;
  logic [31:0] ld_word;
  logic        done;
  logic        accept;
  logic        rsp_set;
  logic [7:0]  rx_next;

  // Upper address bits beyond ADDR_WIDTH go out as zero.
  assign addr24    = 24'(addr_q);
  assign cmd_ready = (state_q == ST_IDLE);

  always_comb begin
    state_n   = state_q;
    cnt_n     = '0;
    ld        = 1'b0;
    ld_mode   = SH_SPI;
    ld_clocks = 4'd8;
    ld_word   = 32'h0;
    accept    = 1'b0;
    rsp_set   = 1'b0;
    unique case (state_q)
      ST_STARTUP: begin
        if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
          ld      = 1'b1;
          ld_word = msb_word(PSRAM_RESET_ENABLE);
          state_n = ST_RST_EN;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_RST_EN: if (done) state_n = ST_GAP;
      ST_GAP: begin
        if (cnt_q == CW'(CE_HIGH_CYCLES - 1)) begin
          ld      = 1'b1;
          ld_word = msb_word(PSRAM_RESET);
          state_n = ST_RST;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_RST: if (done) state_n = ST_CE_HIGH;
      ST_CE_HIGH: begin
        if (cnt_q == CW'(CE_HIGH_CYCLES - 1))
          state_n = ST_IDLE;
        else
          cnt_n = cnt_q + 1'b1;
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          ld      = 1'b1;
          ld_word = msb_word(cmd_write ? PSRAM_QUAD_WRITE
                                       : PSRAM_QUAD_READ);
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        if (done) begin
          ld        = 1'b1;
          ld_mode   = SH_QOUT;
          ld_clocks = 4'd6;
          ld_word   = {addr24, 8'h00};
          state_n   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (done) begin
          ld = 1'b1;
          if (wr_q) begin
            ld_mode   = SH_QOUT;
            ld_clocks = 4'd2;
            ld_word   = msb_word(wdata_q);
            state_n   = ST_DATA;
          end else begin
            ld_mode   = SH_QIN;
            ld_clocks = 4'(WAIT_CLOCKS);
            state_n   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (done) begin
          ld        = 1'b1;
          ld_mode   = SH_QIN;
          ld_clocks = 4'd2;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (done) begin
          rsp_set = ~wr_q;
          state_n = ST_CE_HIGH;
        end
      end
      default: state_n = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rsp_valid <= rsp_set;
      if (rsp_set)
        rsp_rdata <= rx_next;
      if (state_n == ST_IDLE)
        init_done <= 1'b1;
      if (accept) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  end

  psram_shift_engine u_eng (
    .clock   (clock),
    .reset   (reset),
    .load    (ld),
    .mode    (ld_mode),
    .clocks  (ld_clocks),
    .word    (ld_word),
    .sio_in  (psram_sio_in),
    .sclk    (psram_sclk),
    .ce_n    (psram_ce_n),
    .sio_out (psram_sio_out),
    .sio_oe  (psram_sio_oe),
    .done    (done),
    .rx_next (rx_next)
  );

endmodule

// File: tb/tb_psram_qspi_controller.sv
// Bench for psram_qspi_controller: cycle-accurate pin model derived from
// the transaction rules, pin decoder, directed and random traffic.
module tb_psram_qspi_controller;

  localparam int S  = 10;
  localparam int C  = 4;
  localparam int W  = 6;
  localparam int AW = 23;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_wdata = 8'h00;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          init_done;
  logic          psram_sclk;
  logic          psram_ce_n;
  logic [3:0]    psram_sio_out;
  logic [3:0]    psram_sio_oe;
  logic [3:0]    psram_sio_in = 4'h0;

  always #5 clock = ~clock;

  psram_qspi_controller #(
    .ADDR_WIDTH     (AW),
    .STARTUP_CYCLES (S),
    .CE_HIGH_CYCLES (C),
    .WAIT_CLOCKS    (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .init_done     (init_done),
    .psram_sclk    (psram_sclk),
    .psram_ce_n    (psram_ce_n),
    .psram_sio_out (psram_sio_out),
    .psram_sio_oe  (psram_sio_oe),
    .psram_sio_in  (psram_sio_in)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state: reference edge is the last reset edge (init)
  // or the accept edge of the current transaction.
  bit         started = 0;
  bit         in_txn = 0;
  int         ref_cyc = 0;
  bit         t_wr;
  logic [7:0] t_rd;
  int         t_nclk;
  logic [3:0] e_oe [0:21];
  logic [3:0] e_out[0:21];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] next_rd = 8'hC3;
  int         acc_count = 0;
  int         rsp_seen = 0;

  // Pin decoder state.
  bit         dec_act = 0;
  int         dk = 0;
  logic [7:0] d_op;
  logic [23:0] d_addr;
  logic [7:0] d_wd;
  logic [7:0] ops[$];
  logic [23:0] last_addr;
  logic [7:0] last_wd;
  int         hi_run = 0;
  bit         seen_act = 0;
  int         min_gap = 1000;

  always @(negedge clock) begin : model
    int d, k;
    logic e_ce, e_sclk, e_rdy, e_done, e_rv;
    logic [3:0] eo, ev;
    logic [7:0] ib;
    logic [23:0] a24;
    logic [7:0] op;
    e_rdy = 1'b0;
    if (started) begin
      d = cyc - ref_cyc;
      e_ce = 1'b1; e_sclk = 1'b0; eo = 4'h0; ev = 4'h0; e_rv = 1'b0;
      psram_sio_in = 4'($urandom);
      if (!in_txn) begin
        e_done = (d >= S + 40);
        e_rdy  = e_done;
        if ((d >= S && d < S + 16) || (d >= S + 20 && d < S + 36)) begin
          ib = (d < S + 16) ? 8'h66 : 8'h99;
          k = (d < S + 16) ? (d - S) / 2 : (d - S - 20) / 2;
          e_ce = 1'b0;
          e_sclk = (d % 2) == 1;
          eo = 4'b0001;
          ev = {3'b000, ib[7 - k]};
        end
      end else begin
        e_done = 1'b1;
        e_rdy = (d >= 2 * t_nclk + C);
        if (d < 2 * t_nclk) begin
          k = d / 2;
          e_ce = 1'b0;
          e_sclk = (d % 2) == 1;
          eo = e_oe[k];
          ev = e_out[k];
          if (!t_wr && k == 20) psram_sio_in = t_rd[7:4];
          if (!t_wr && k == 21) psram_sio_in = t_rd[3:0];
        end
        e_rv = !t_wr && (d == 2 * t_nclk);
      end
      check("ce_n", psram_ce_n, e_ce);
      check("sclk", psram_sclk, e_sclk);
      check("sio_oe", psram_sio_oe, eo);
      if (eo != 4'h0) check("sio_out", psram_sio_out, ev);
      check("cmd_ready", cmd_ready, e_rdy);
      check("init_done", init_done, e_done);
      check("rsp_valid", rsp_valid, e_rv);
      if (e_rv) last_rd = t_rd;
      check("rsp_rdata", rsp_rdata, last_rd);
    end
    if (rsp_valid === 1'b1) rsp_seen++;
    // Pin decoder, independent of the model above.
    if (psram_ce_n === 1'b0) begin
      if (seen_act && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      dec_act = 1;
      seen_act = 1;
      if (psram_sclk === 1'b1) begin
        if (dk < 8) d_op = {d_op[6:0], psram_sio_out[0]};
        else if (dk < 14) d_addr = {d_addr[19:0], psram_sio_out};
        else if (psram_sio_oe == 4'hF) d_wd = {d_wd[3:0], psram_sio_out};
        dk++;
      end
    end else begin
      hi_run++;
      if (dec_act) begin
        ops.push_back(d_op);
        last_addr = d_addr;
        last_wd = d_wd;
      end
      dec_act = 0;
      dk = 0;
    end
    if (reset) begin
      started = 1;
      in_txn = 0;
      ref_cyc = cyc + 1;
      last_rd = 8'h00;
      seen_act = 0;
    end else if (started && cmd_valid && e_rdy) begin
      in_txn = 1;
      ref_cyc = cyc + 1;
      t_wr = cmd_write;
      t_rd = next_rd;
      a24 = {1'b0, cmd_addr};
      op = cmd_write ? 8'h38 : 8'hEB;
      for (int i = 0; i < 8; i++) begin
        e_oe[i] = 4'b0001;
        e_out[i] = {3'b000, op[7 - i]};
      end
      for (int j = 0; j < 6; j++) begin
        e_oe[8 + j] = 4'hF;
        e_out[8 + j] = a24[23 - 4 * j -: 4];
      end
      for (int i = 14; i < 22; i++) begin
        e_oe[i] = 4'h0;
        e_out[i] = 4'h0;
      end
      if (cmd_write) begin
        e_oe[14] = 4'hF; e_out[14] = cmd_wdata[7:4];
        e_oe[15] = 4'hF; e_out[15] = cmd_wdata[3:0];
        t_nclk = 16;
      end else begin
        t_nclk = 14 + W + 2;
      end
      acc_count++;
    end
  end

  task automatic issue(input bit w, input logic [AW-1:0] a,
                       input logic [7:0] wd, input logic [7:0] rd,
                       input bit hold);
    int start;
    int t;
    start = acc_count;
    t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    next_rd   = rd;
    while (acc_count == start && t < 300) begin
      @(posedge clock);
      #2;
      t++;
    end
    if (acc_count == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout cyc=%0d got=none expected=accept", cyc);
    end
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = 8'($urandom);
    end
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  int rs;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    // Request pending through the whole power-up sequence.
    issue(1'b0, 23'h000010, 8'h00, 8'hC3, 1'b0);
    idle_wait(60);
    check("init_op0", ops[0], 8'h66);
    check("init_op1", ops[1], 8'h99);
    check("rd_op", ops[2], 8'hEB);
    check("rd_addr", last_addr, 24'h000010);
    check("rd_data", rsp_rdata, 8'hC3);
    check("rd_rsp_count", rsp_seen, 1);

    issue(1'b1, 23'h1A2B3C, 8'h5A, 8'h00, 1'b0);
    idle_wait(60);
    check("wr_op", ops[ops.size() - 1], 8'h38);
    check("wr_addr", last_addr, 24'h1A2B3C);
    check("wr_data", last_wd, 8'h5A);
    check("wr_no_rsp", rsp_seen, 1);
    check("wr_rdata_hold", rsp_rdata, 8'hC3);

    // Back-to-back: read then write with cmd_valid held.
    issue(1'b0, 23'h7FFFFF, 8'h00, 8'h96, 1'b1);
    issue(1'b1, 23'h000001, 8'hE1, 8'h00, 1'b0);
    idle_wait(60);
    check("b2b_addr", last_addr, 24'h000001);
    check("b2b_rdata", rsp_rdata, 8'h96);

    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), AW'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0));
      if (!cmd_valid) idle_wait($urandom_range(0, 5));
    end
    cmd_valid = 1'b0;
    idle_wait(60);

    // Reset lands on E20 of a read.
    rs = rsp_seen;
    issue(1'b0, 23'h00ABCD, 8'h00, 8'h3C, 1'b0);
    repeat (19) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    check("rst_init_done", init_done, 1'b0);
    check("rst_ce_n", psram_ce_n, 1'b1);
    check("rst_rdata", rsp_rdata, 8'h00);
    issue(1'b0, 23'h000200, 8'h00, 8'h81, 1'b0);
    idle_wait(60);
    check("rst_reinit_op0", ops[ops.size() - 3], 8'h66);
    check("rst_reinit_op1", ops[ops.size() - 2], 8'h99);
    check("rst_rsp_count", rsp_seen, rs + 1);
    check("rst_rd_data", rsp_rdata, 8'h81);
    issue(1'b1, 23'h400000, 8'h77, 8'h00, 1'b0);
    idle_wait(60);
    check("post_wr_addr", last_addr, 24'h400000);
    check("min_ce_gap", (min_gap >= C), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
